// File: rtl/img_cap_pkg.sv
// Shared definitions for the image-capture frame-buffer path: strobe polarity
// constants, the frame-buffer port state type and default frame geometry.
package img_cap_pkg;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

  localparam int FRAME_W = 640;
  localparam int FRAME_H = 480;
  localparam int FRAME_WORDS_DEF = FRAME_W * FRAME_H;

  // One-hot so that any corrupted encoding is distinguishable and recovers to S_EMPTY.
  typedef enum logic [3:0] {
    S_EMPTY = 4'b0001,
    S_WRITE = 4'b0010,
    S_FULL  = 4'b0100,
    S_READ  = 4'b1000
  } fb_state_t;

endpackage

// File: rtl/fb_port_ctrl_if.sv
// Avalon-MM single-word port between a frame-buffer controller (master) and
// the DDR memory controller (slave).
interface fb_port_ctrl_if #(
  parameter int ADDR_WIDTH = 29,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] avl_addr;
  logic                  avl_write_req;
  logic                  avl_read_req;
  logic [DATA_WIDTH-1:0] avl_wdata;
  logic [DATA_WIDTH-1:0] avl_rdata;
  logic                  avl_rdata_valid;
  logic                  avl_ready_in;

  modport master (
    output avl_addr, avl_write_req, avl_read_req, avl_wdata,
    input  avl_rdata, avl_rdata_valid, avl_ready_in
  );

  modport slave (
    input  avl_addr, avl_write_req, avl_read_req, avl_wdata,
    output avl_rdata, avl_rdata_valid, avl_ready_in
  );
endinterface

// File: rtl/fb_rd_tracker.sv
// Tracks outstanding read requests and counts frame returns; flags the final
// return of a frame and whether another read may be issued.
module fb_rd_tracker
  import img_cap_pkg::*;
#(
  parameter int FRAME_WORDS = 307200,
  parameter int MAX_PEND    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic rd_acc,
  input  logic rdata_valid,
  input  logic in_read,
  output logic issue_ok,
  output logic last_return
);
  localparam int PEND_W = $clog2(MAX_PEND + 1);
  localparam int CNT_W  = $clog2(FRAME_WORDS + 1);
  localparam logic [PEND_W-1:0] PEND_LIMIT = PEND_W'(MAX_PEND);
  localparam logic [CNT_W-1:0]  LAST_RET   = CNT_W'(FRAME_WORDS - 1);

  logic [PEND_W-1:0] pend;
  logic [CNT_W-1:0]  ret_cnt;
  logic              dec;
  logic              count_ret;

  // Stray returns with nothing outstanding (e.g. after a reset) never underflow pend.
  assign dec         = rdata_valid && (pend != '0);
  assign count_ret   = rdata_valid && in_read;
  assign last_return = count_ret && (ret_cnt == LAST_RET);
  assign issue_ok    = (pend < PEND_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend    <= '0;
      ret_cnt <= '0;
    end else begin
      if (rd_acc && !dec)
        pend <= pend + PEND_W'(1);
      else if (!rd_acc && dec)
        pend <= pend - PEND_W'(1);

      if (last_return)
        ret_cnt <= '0;
      else if (count_ret)
        ret_cnt <= ret_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/fb_port_ctrl.sv
// Frame-buffer port controller: converts active-low write/read strobes into
// linear-address Avalon-MM requests and reports full/rd_done for ping-pong use.
module fb_port_ctrl
  import img_cap_pkg::*;
#(
  parameter int ADDR_WIDTH  = 29,
  parameter int DATA_WIDTH  = 32,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_WORDS = 307200,
  parameter int MAX_PEND    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  avl_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic                  full,
  output logic                  rd_done,
  fb_port_ctrl_if.master        avl
);
  localparam int PTR_W = $clog2(FRAME_WORDS + 1);
  localparam logic [PTR_W-1:0]      LAST_WORD = PTR_W'(FRAME_WORDS - 1);
  localparam logic [PTR_W-1:0]      END_PTR   = PTR_W'(FRAME_WORDS);
  localparam logic [ADDR_WIDTH-1:0] BASE_A    = ADDR_WIDTH'(BASE_ADDR);

  fb_state_t        state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             in_read;
  logic             write_req;
  logic             read_req;
  logic             wr_acc;
  logic             rd_acc;
  logic             issue_ok;
  logic             last_return;

  assign in_read   = (state == S_READ);
  assign write_req = (wr_en == ASSERT_L) && ((state == S_EMPTY) || (state == S_WRITE));
  assign read_req  = (rd_en == ASSERT_L) && ((state == S_FULL) || in_read)
                     && (rd_ptr < END_PTR) && issue_ok;
  assign wr_acc    = write_req && avl.avl_ready_in;
  assign rd_acc    = read_req && avl.avl_ready_in;

  assign avl.avl_write_req = write_req;
  assign avl.avl_read_req  = read_req;
  assign avl.avl_wdata     = wr_data;
  assign avl.avl_addr      = write_req ? BASE_A + ADDR_WIDTH'(wr_ptr)
                                       : BASE_A + ADDR_WIDTH'(rd_ptr);
  assign avl_ready         = avl.avl_ready_in;

  fb_rd_tracker #(
    .FRAME_WORDS (FRAME_WORDS),
    .MAX_PEND    (MAX_PEND)
  ) u_rd_tracker (
    .clk         (clk),
    .reset       (reset),
    .rd_acc      (rd_acc),
    .rdata_valid (avl.avl_rdata_valid),
    .in_read     (in_read),
    .issue_ok    (issue_ok),
    .last_return (last_return)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_EMPTY;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      full    <= 1'b0;
      rd_done <= 1'b1;
    end else begin
      case (state)
        S_EMPTY: if (wr_acc) begin
          state   <= S_WRITE;
          rd_done <= 1'b0;
          wr_ptr  <= wr_ptr + PTR_W'(1);
        end
        S_WRITE: if (wr_acc) begin
          if (wr_ptr == LAST_WORD) begin
            state  <= S_FULL;
            full   <= 1'b1;
            wr_ptr <= '0;
          end else begin
            wr_ptr <= wr_ptr + PTR_W'(1);
          end
        end
        S_FULL: if (rd_acc) begin
          state  <= S_READ;
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        S_READ: begin
          // All reads are issued before the last return, so no accept can coincide with it.
          if (last_return) begin
            state   <= S_EMPTY;
            full    <= 1'b0;
            rd_done <= 1'b1;
            rd_ptr  <= '0;
          end else if (rd_acc) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
          end
        end
        default: begin
          state   <= S_EMPTY;
          wr_ptr  <= '0;
          rd_ptr  <= '0;
          full    <= 1'b0;
          rd_done <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data       <= avl.avl_rdata;
      rd_data_valid <= avl.avl_rdata_valid;
    end
  end
endmodule

// File: tb/tb_fb_port_ctrl.sv
// Bench for fb_port_ctrl: vector table, directed frame sequences and a random
// phase, all checked against a count-based model of the frame buffer.
module tb_fb_port_ctrl;
  localparam int AW   = 29;
  localparam int DW   = 32;
  localparam int BASE = 100;
  localparam int FW   = 16;
  localparam int MP   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en, rd_en;
  logic [DW-1:0] wr_data;
  logic          avl_ready;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid, full, rd_done;

  fb_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fb_port_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE),
    .FRAME_WORDS(FW), .MAX_PEND(MP)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data),
    .avl_ready(avl_ready), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .full(full), .rd_done(rd_done), .avl(bus)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [DW-1:0] data; } ret_t;
  typedef struct {
    logic w_en, r_en, rdy;
    logic exp_w, exp_r, exp_full, exp_done;
    logic [AW-1:0] exp_addr;
  } vec_t;

  int checks = 0, failures = 0;
  int cyc = 0, lat = 3, last_due = 0;
  int written = 0, issued = 0, returned = 0, outstanding = 0, frames = 0;
  int rdv_count = 0;
  logic [DW-1:0] img [FW];
  logic [DW-1:0] mem [64];
  ret_t memq[$];
  logic prev_valid = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic both_prev = 1'b0;
  logic s_w, s_r, s_full, s_done;
  logic [AW-1:0] s_addr;
  vec_t vt [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int idx(input logic [AW-1:0] a);
    return int'(a - AW'(BASE)) & 63;
  endfunction

  // One clock: drive at negedge, check, let the memory follow the DUT bus, advance the model.
  task automatic step(input logic w_en, input logic r_en, input logic rdy, input logic [DW-1:0] wd);
    logic present, exp_w, exp_r, acc_w, acc_r, nxt_valid;
    logic [DW-1:0] pdata, nxt_data;
    int due;
    present = (memq.size() > 0) && (memq[0].due <= cyc);
    pdata = present ? memq[0].data : DW'($urandom);
    wr_en = w_en; rd_en = r_en; wr_data = wd;
    bus.avl_ready_in = rdy; bus.avl_rdata_valid = present; bus.avl_rdata = pdata;
    #1;
    exp_w = !w_en && (written < FW);
    exp_r = !r_en && (written == FW) && (issued < FW) && (outstanding < MP);
    s_w = bus.avl_write_req; s_r = bus.avl_read_req; s_addr = bus.avl_addr;
    s_full = full; s_done = rd_done;
    if (rd_data_valid) rdv_count++;
    chk("write_req", s_w, exp_w);
    chk("read_req", s_r, exp_r);
    if (exp_w) begin
      chk("wr_addr", s_addr, AW'(BASE + written));
      chk("wdata", bus.avl_wdata, wd);
    end
    if (exp_r) chk("rd_addr", s_addr, AW'(BASE + issued));
    chk("full", s_full, written == FW);
    chk("rd_done", s_done, written == 0);
    chk("avl_ready", avl_ready, rdy);
    chk("rd_data_valid", rd_data_valid, prev_valid);
    if (prev_valid) chk("rd_data", rd_data, prev_data);
    if (both_prev && !r_en && issued < FW) chk("issue_after_both", s_r, 1'b1);
    both_prev = 1'b0;

    if (bus.avl_write_req && rdy) mem[idx(bus.avl_addr)] = bus.avl_wdata;
    if (bus.avl_read_req && rdy) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{due, mem[idx(bus.avl_addr)]});
    end
    if (present) void'(memq.pop_front());
    chk("max_outstanding", memq.size() <= MP, 1'b1);

    acc_w = exp_w && rdy;
    acc_r = exp_r && rdy;
    if (present && acc_r && outstanding == MP - 1) both_prev = 1'b1;
    nxt_valid = present;
    nxt_data = (present && written == FW) ? img[returned] : pdata;
    if (acc_w) begin img[written] = wd; written++; end
    if (acc_r) begin issued++; outstanding++; end
    if (present) begin
      if (outstanding > 0) outstanding--;
      if (written == FW) begin
        returned++;
        if (returned == FW) begin written = 0; issued = 0; returned = 0; frames++; end
      end
    end
    @(posedge clk);
    cyc++;
    prev_valid = nxt_valid;
    prev_data = nxt_data;
    @(negedge clk);
  endtask

  task automatic write_frame(input bit toggle);
    int n = 0;
    while (written < FW && n < 200) begin
      step(1'b0, 1'b1, toggle ? n[0] : 1'b1, DW'(written) + (DW'(frames) << 16));
      n++;
    end
    chk("frame_full", full, 1'b1);
  endtask

  task automatic read_frame(input int l, input bit toggle);
    int n = 0;
    lat = l;
    while (written != 0 && n < 400) begin
      step(1'b1, 1'b0, toggle ? n[0] : 1'b1, DW'($urandom));
      n++;
    end
    chk("drain_rd_done", rd_done, 1'b1);
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, AW'(0)};
    vt[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, AW'(BASE)};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, AW'(BASE)};
    vt[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, AW'(BASE)};
    vt[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, AW'(0)};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, AW'(BASE + 1)};
    for (int i = 0; i < 64; i++) mem[i] = '0;

    reset = 1'b0; wr_en = 1'b1; rd_en = 1'b1; wr_data = '0;
    bus.avl_ready_in = 1'b1; bus.avl_rdata_valid = 1'b0; bus.avl_rdata = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_full", full, 1'b0);
    chk("rst_rd_done", rd_done, 1'b1);
    chk("rst_rd_data_valid", rd_data_valid, 1'b0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_write_req", bus.avl_write_req, 1'b0);
    chk("rst_read_req", bus.avl_read_req, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      step(vt[i].w_en, vt[i].r_en, vt[i].rdy, DW'(32'hA0 + i));
      chk("vec_write_req", s_w, vt[i].exp_w);
      chk("vec_read_req", s_r, vt[i].exp_r);
      chk("vec_full", s_full, vt[i].exp_full);
      chk("vec_rd_done", s_done, vt[i].exp_done);
      if (vt[i].exp_w) chk("vec_addr", s_addr, vt[i].exp_addr);
    end

    // Reset pulse in the middle of a fill with seven words written
    while (written < 7 && cyc < 100) step(1'b0, 1'b1, 1'b1, DW'(written));
    chk("pre_reset_written", rd_done, 1'b0);
    wr_en = 1'b1; reset = 1'b0;
    #1;
    chk("midrst_full", full, 1'b0);
    chk("midrst_rd_done", rd_done, 1'b1);
    chk("midrst_write_req", bus.avl_write_req, 1'b0);
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    written = 0; issued = 0; returned = 0; outstanding = 0;
    prev_valid = 1'b0; both_prev = 1'b0; memq.delete();

    write_frame(1'b0);
    step(1'b0, 1'b1, 1'b1, DW'(32'hDEAD));
    chk("no_overwrite_req", s_w, 1'b0);

    rdv_count = 0;
    read_frame(3, 1'b0);
    step(1'b1, 1'b1, 1'b1, '0);
    chk("rdv_pulses", rdv_count, 16);

    write_frame(1'b1);
    read_frame(10, 1'b1);

    write_frame(1'b0);
    read_frame(1, 1'b0);

    begin
      int f0 = frames;
      int n = 0;
      while (frames < f0 + 3 && n < 4000) begin
        lat = $urandom_range(1, 8);
        step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 9) < 7, DW'($urandom));
        n++;
      end
      chk("random_frames_done", frames >= f0 + 3, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
